// File: rtl/result_frame_tx_if.sv
// Request/acknowledge and serial-line bundle of result_frame_tx.
// The master side raises requests and supplies payload; the slave side
// (the transmitter) returns acknowledges, busy/frame_done and the UART line.
interface result_frame_tx_if;
  logic        go_success;
  logic        go_unsucces;
  logic        reconfig_ok;
  logic [31:0] gold_nonce;
  logic [7:0]  hash_frequency;
  logic        tx;
  logic        busy;
  logic        ack_success;
  logic        ack_unsucces;
  logic        frame_done;

  modport master (
    output go_success, go_unsucces, reconfig_ok, gold_nonce, hash_frequency,
    input  tx, busy, ack_success, ack_unsucces, frame_done
  );

  modport slave (
    input  go_success, go_unsucces, reconfig_ok, gold_nonce, hash_frequency,
    output tx, busy, ack_success, ack_unsucces, frame_done
  );
endinterface

// File: rtl/result_frame_tx.sv
// result_frame_tx: miner-to-host response transmitter (clk_25 domain).
// Sends SUCCESS (55 n0 n1 n2 n3 chk), RECONFIG (5A hf chk) and UNSUCCESS
// (AA AA) frames on a UART line, 8N1 LSB first; chk is the XOR of all
// preceding frame bytes. host_break is a synchronous active-high reset.
// Optional build macro RESULT_FRAME_TX_PARITY_EN switches every byte to 8E1.
module result_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned GAP_CLKS     = 0
) (
  input  logic             clk_25,
  input  logic             host_break,
  result_frame_tx_if.slave bus
);

  // One timer serves bit periods and inter-byte gaps, so size it for the longer.
  localparam int unsigned TMAX = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
`ifdef RESULT_FRAME_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx, r_byte_idx, r_last_idx;
  logic [5:0][7:0] r_frame;
  logic            r_pending, r_tx, r_busy, r_ack_success, r_ack_unsucces, r_frame_done;

  logic            w_bit_end, w_gap_end, w_last_byte, w_req_reconfig;
  logic            w_accept, w_take_success, w_take_reconfig, w_take_unsucces;
  logic            w_frame_end, w_tx_next;
  logic [7:0]      w_cur_byte;
  logic [5:0][7:0] w_frame;
  logic [2:0]      w_last_idx;

  assign w_bit_end      = (r_timer == BIT_LAST);
  assign w_gap_end      = (r_timer == GAP_LAST);
  assign w_last_byte    = (r_byte_idx == r_last_idx);
  assign w_req_reconfig = bus.reconfig_ok | r_pending;
  assign w_cur_byte     = r_frame[r_byte_idx];

  // Next state, acceptance arbitration and the line level for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_take_success  = 1'b0;
    w_take_reconfig = 1'b0;
    w_take_unsucces = 1'b0;
    w_frame_end     = 1'b0;
    w_tx_next       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (bus.go_success || w_req_reconfig || bus.go_unsucces) begin
          w_accept     = 1'b1;
          w_state_next = S_START;
          if (bus.go_success)  w_take_success  = 1'b1;
          else if (w_req_reconfig) w_take_reconfig = 1'b1;
          else                 w_take_unsucces = 1'b1;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx_next = w_cur_byte[r_bit_idx];
        if (w_bit_end && r_bit_idx == 3'd7) begin
`ifdef RESULT_FRAME_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef RESULT_FRAME_TX_PARITY_EN
      S_PARITY: begin
        w_tx_next = ^w_cur_byte;
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (w_last_byte) begin
            w_frame_end  = 1'b1;
            w_state_next = S_IDLE;
          end else if (GAP_CLKS == 0) begin
            w_state_next = S_START;
          end else begin
            w_state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_gap_end) w_state_next = S_START;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame contents for the request being accepted, checksum included.
  always_comb begin
    w_frame    = '0;
    w_last_idx = 3'd0;
    if (w_take_success) begin
      w_frame[0] = 8'h55;
      w_frame[1] = bus.gold_nonce[7:0];
      w_frame[2] = bus.gold_nonce[15:8];
      w_frame[3] = bus.gold_nonce[23:16];
      w_frame[4] = bus.gold_nonce[31:24];
      w_frame[5] = 8'h55 ^ bus.gold_nonce[7:0] ^ bus.gold_nonce[15:8]
                 ^ bus.gold_nonce[23:16] ^ bus.gold_nonce[31:24];
      w_last_idx = 3'd5;
    end else if (w_take_reconfig) begin
      w_frame[0] = 8'h5A;
      w_frame[1] = bus.hash_frequency;
      w_frame[2] = 8'h5A ^ bus.hash_frequency;
      w_last_idx = 3'd2;
    end else if (w_take_unsucces) begin
      w_frame[0] = 8'hAA;
      w_frame[1] = 8'hAA;
      w_last_idx = 3'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_25) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (host_break) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Timers, indices, pending reconfig and registered outputs.
  always_ff @(posedge clk_25) begin
    if (host_break) begin
      r_timer        <= '0;
      r_bit_idx      <= 3'd0;
      r_byte_idx     <= 3'd0;
      r_last_idx     <= 3'd0;
      r_pending      <= 1'b0;
      r_tx           <= 1'b1;
      r_busy         <= 1'b0;
      r_ack_success  <= 1'b0;
      r_ack_unsucces <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_state_next != r_state) r_timer <= '0;
      else                                              r_timer <= r_timer + TW'(1);

      // Eight bits per byte, so the 3-bit index wraps back to 0 by itself.
      if (r_state == S_DATA && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_accept) begin
        r_byte_idx <= 3'd0;
        r_last_idx <= w_last_idx;
      end else if (r_state == S_STOP && w_bit_end && !w_last_byte) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end

      // Pulses arriving while one is pending merge; a pulse during a success
      // acceptance is kept for the next frame.
      r_pending      <= (r_pending | bus.reconfig_ok) & ~w_take_reconfig;
      r_tx           <= w_tx_next;
      r_ack_success  <= w_take_success;
      r_ack_unsucces <= w_take_unsucces;
      r_frame_done   <= w_frame_end;
      if (w_accept)         r_busy <= 1'b1;
      else if (w_frame_end) r_busy <= 1'b0;
    end
  end

  // Payload snapshot taken at acceptance.
  always_ff @(posedge clk_25) begin
    // NOTE: the frame buffer has no reset; it is always reloaded at acceptance before being read.
    if (w_accept) r_frame <= w_frame;
  end

  assign bus.tx           = r_tx;
  assign bus.busy         = r_busy;
  assign bus.ack_success  = r_ack_success;
  assign bus.ack_unsucces = r_ack_unsucces;
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_result_frame_tx.sv
// Self-checking bench for result_frame_tx (CLKS_PER_BIT=4, GAP_CLKS=0).
// A UART decoder turns the line back into bytes; a frame-level model builds
// the expected byte list and timing from the protocol rules.
module tb_result_frame_tx;
  localparam int CLKS = 4;
`ifdef RESULT_FRAME_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam int BYTE_CLKS = CLKS * BITS_PER_BYTE;

  typedef enum int {K_SUCCESS, K_RECONFIG, K_UNSUCCESS} kind_t;
  typedef struct { logic [7:0] data; logic stop_ok; logic par_ok; } rx_byte_t;

  logic clk_25 = 1'b0;
  logic host_break;
  result_frame_tx_if bus ();

  result_frame_tx #(.CLKS_PER_BIT(CLKS), .GAP_CLKS(0)) dut (
    .clk_25    (clk_25),
    .host_break(host_break),
    .bus       (bus)
  );

  always #5 clk_25 = ~clk_25;

  int         checks = 0;
  int         errors = 0;
  rx_byte_t   rx_q[$];
  logic [7:0] exp_q[$];
  logic       rx_brk;

  // Reference model: byte list of a frame, checksum = XOR of preceding bytes.
  task automatic build_expected(input kind_t k, input logic [31:0] n, input logic [7:0] hf);
    logic [7:0] chk;
    exp_q.delete();
    case (k)
      K_SUCCESS: begin
        exp_q.push_back(8'h55);
        for (int i = 0; i < 4; i++) exp_q.push_back(n[8*i +: 8]);
      end
      K_RECONFIG: begin
        exp_q.push_back(8'h5A);
        exp_q.push_back(hf);
      end
      default: exp_q.push_back(8'hAA);
    endcase
    chk = 8'h00;
    foreach (exp_q[i]) chk ^= exp_q[i];
    exp_q.push_back(chk);
  endtask

  function automatic string exp_string();
    string s;
    s = "";
    foreach (exp_q[i]) s = {s, $sformatf("%02x ", exp_q[i])};
    return s;
  endfunction

  // Drains decoded bytes; 's' marks a bad stop bit, 'p' a bad parity bit.
  function automatic string rx_string();
    string s;
    s = "";
    while (rx_q.size() > 0) begin
      rx_byte_t r;
      r = rx_q.pop_front();
      s = {s, $sformatf("%02x", r.data)};
      if (r.stop_ok !== 1'b1) s = {s, "s"};
      if (r.par_ok !== 1'b1) s = {s, "p"};
      s = {s, " "};
    end
    return s;
  endfunction

  task automatic rx_wait(input int n);
    repeat (n) begin
      @(posedge clk_25); #1;
      if (bus.busy !== 1'b1) rx_brk = 1'b1;
    end
  endtask

  // UART receiver: mid-bit sampling; bytes cut short by a reset are dropped.
  initial begin : uart_rx
    logic [7:0] d;
    logic       par, stop;
    forever begin
      @(posedge clk_25); #1;
      if (bus.tx === 1'b0) begin
        rx_brk = 1'b0;
        rx_wait(CLKS / 2);
        if (bus.tx !== 1'b0) rx_brk = 1'b1;
        for (int b = 0; b < 8; b++) begin
          rx_wait(CLKS);
          d[b] = bus.tx;
        end
        par = ^d;
`ifdef RESULT_FRAME_TX_PARITY_EN
        rx_wait(CLKS);
        par = bus.tx;
`endif
        rx_wait(CLKS);
        stop = bus.tx;
        if (!rx_brk) rx_q.push_back('{data: d, stop_ok: (stop === 1'b1), par_ok: (par === ^d)});
      end
    end
  end

  // Runs one frame from request to busy fall, dropping level requests on ack.
  // Indices are in cycles from the first sample with busy high.
  task automatic run_frame(input int reconf_at, input bit change_nonce,
                           output int rise_wait, output int busy_cyc, output int done_cnt,
                           output int done_at, output int ack_s_at, output int ack_u_at,
                           output int ack_cnt, output int tx_low_at, output bit timeout);
    int idx;
    rise_wait = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; ack_s_at = -1;
    ack_u_at = -1; ack_cnt = 0; tx_low_at = -1; timeout = 1'b0;
    do begin
      @(posedge clk_25); #1;
      rise_wait++;
    end while (bus.busy !== 1'b1 && rise_wait < 20);
    if (bus.busy !== 1'b1) begin
      timeout = 1'b1;
      bus.reconfig_ok = 1'b0;
      return;
    end
    idx = 0;
    while (1) begin
      if (bus.ack_success === 1'b1) begin ack_cnt++; ack_s_at = idx; bus.go_success = 1'b0; end
      if (bus.ack_unsucces === 1'b1) begin ack_cnt++; ack_u_at = idx; bus.go_unsucces = 1'b0; end
      if (bus.frame_done === 1'b1) begin done_cnt++; done_at = idx; end
      if (bus.busy === 1'b1) busy_cyc++;
      if (tx_low_at < 0 && bus.tx === 1'b0) tx_low_at = idx;
      if (bus.busy !== 1'b1 || idx > 2000) break;
      bus.reconfig_ok = (idx == reconf_at);
      if (change_nonce && idx == 1) bus.gold_nonce = 32'hFFFF_FFFF;
      @(posedge clk_25); #1;
      idx++;
    end
    bus.reconfig_ok = 1'b0;
    if (bus.busy === 1'b1) timeout = 1'b1;
  endtask

  task automatic test_reset();
    host_break = 1'b1;
    repeat (3) @(posedge clk_25);
    #1;
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.ack_success, bus.ack_unsucces, bus.frame_done} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {bus.ack_success, bus.ack_unsucces, bus.frame_done});
    end
    host_break = 1'b0;
    repeat (3) @(posedge clk_25);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b tx=%b expected busy=0 tx=1", bus.busy, bus.tx);
    end
    rx_q.delete();
  endtask

  task automatic test_success(input bit change_nonce);
    int rw, bc, dc, da, as, au, ac, tl;
    bit to;
    string got, exp;
    build_expected(K_SUCCESS, 32'h1234_5678, 8'h00);
    @(posedge clk_25); #1;
    bus.gold_nonce = 32'h1234_5678;
    bus.go_success = 1'b1;
    run_frame(-1, change_nonce, rw, bc, dc, da, as, au, ac, tl, to);
    got = rx_string(); exp = exp_string();
    checks++; if (to) begin errors++; $display("FAIL success_timeout: got busy stuck/never expected frame"); end
    checks++; if (got != exp) begin errors++; $display("FAIL success_bytes (snap=%0d): got %s expected %s", change_nonce, got, exp); end
    checks++; if (rw !== 1) begin errors++; $display("FAIL success_accept_latency: got %0d expected 1", rw); end
    checks++; if (as !== 0 || ac !== 1) begin errors++; $display("FAIL success_ack: got at=%0d count=%0d expected at=0 count=1", as, ac); end
    checks++; if (tl !== 1) begin errors++; $display("FAIL success_tx_low: got %0d expected 1", tl); end
    checks++; if (bc !== 6 * BYTE_CLKS) begin errors++; $display("FAIL success_busy_len: got %0d expected %0d", bc, 6 * BYTE_CLKS); end
    checks++; if (dc !== 1 || da !== 6 * BYTE_CLKS) begin
      errors++; $display("FAIL success_frame_done: got count=%0d at=%0d expected count=1 at=%0d", dc, da, 6 * BYTE_CLKS);
    end
  endtask

  task automatic test_simultaneous();
    int rw, bc, dc, da, as, au, ac, tl;
    bit to;
    string got, exp;
    repeat (3) @(posedge clk_25);
    #1;
    bus.hash_frequency = 8'h28;
    bus.reconfig_ok    = 1'b1;
    bus.go_unsucces    = 1'b1;
    run_frame(-1, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
    bus.hash_frequency = 8'hC3;
    build_expected(K_RECONFIG, 32'h0, 8'h28);
    got = rx_string(); exp = exp_string();
    checks++; if (to || got != exp) begin errors++; $display("FAIL simul_first_bytes: got %s expected %s", got, exp); end
    checks++; if (ac !== 0) begin errors++; $display("FAIL simul_first_acks: got %0d expected 0", ac); end
    checks++; if (bc !== 3 * BYTE_CLKS) begin errors++; $display("FAIL simul_first_busy: got %0d expected %0d", bc, 3 * BYTE_CLKS); end
    run_frame(-1, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
    build_expected(K_UNSUCCESS, 32'h0, 8'h00);
    got = rx_string(); exp = exp_string();
    checks++; if (to || got != exp) begin errors++; $display("FAIL simul_second_bytes: got %s expected %s", got, exp); end
    checks++; if (rw !== 1) begin errors++; $display("FAIL simul_idle_gap: got %0d expected 1", rw); end
    checks++; if (au !== 0 || ac !== 1) begin errors++; $display("FAIL simul_ack_unsucces: got at=%0d count=%0d expected at=0 count=1", au, ac); end
    checks++; if (bc !== 2 * BYTE_CLKS) begin errors++; $display("FAIL simul_second_busy: got %0d expected %0d", bc, 2 * BYTE_CLKS); end
  endtask

  task automatic test_request_while_busy();
    int rw, bc, dc, da, as, au, ac, tl;
    bit to;
    string got, exp;
    logic [31:0] n;
    n = $urandom();
    @(posedge clk_25); #1;
    bus.gold_nonce     = n;
    bus.hash_frequency = 8'($urandom());
    bus.go_success     = 1'b1;
    build_expected(K_SUCCESS, n, 8'h00);
    run_frame(50, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
    got = rx_string(); exp = exp_string();
    checks++; if (to || got != exp) begin errors++; $display("FAIL busy_req_first_bytes: got %s expected %s", got, exp); end
    build_expected(K_RECONFIG, 32'h0, bus.hash_frequency);
    run_frame(-1, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
    got = rx_string(); exp = exp_string();
    checks++; if (to || got != exp) begin errors++; $display("FAIL busy_req_second_bytes: got %s expected %s", got, exp); end
    checks++; if (rw + tl !== 2) begin errors++; $display("FAIL busy_req_start_delay: got %0d expected 2", rw + tl); end
    checks++; if (ac !== 0) begin errors++; $display("FAIL busy_req_acks: got %0d expected 0", ac); end
  endtask

  task automatic test_reset_midframe();
    int rw, bc, dc, da, as, au, ac, tl, w, idx, busy_seen, done_seen;
    bit to;
    string got, exp;
    logic [31:0] n;
    @(posedge clk_25); #1;
    bus.gold_nonce = $urandom();
    bus.go_success = 1'b1;
    w = 0;
    while (bus.busy !== 1'b1 && w < 20) begin @(posedge clk_25); #1; w++; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_start: got busy=%b expected 1", bus.busy); end
    // Byte 2 data bit 3 spans cycles 96..99 after acceptance.
    idx = 0;
    while (idx < 97) begin
      if (bus.ack_success === 1'b1) bus.go_success = 1'b0;
      bus.reconfig_ok = (idx == 20);
      @(posedge clk_25); #1;
      idx++;
    end
    bus.reconfig_ok = 1'b0;
    host_break = 1'b1;
    @(posedge clk_25); #1;
    checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got tx=%b busy=%b expected tx=1 busy=0", bus.tx, bus.busy);
    end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.frame_done); end
    host_break = 1'b0;
    busy_seen = 0; done_seen = 0;
    repeat (3 * BYTE_CLKS) begin
      @(posedge clk_25); #1;
      if (bus.busy === 1'b1) busy_seen++;
      if (bus.frame_done === 1'b1) done_seen++;
    end
    checks++; if (busy_seen !== 0 || done_seen !== 0) begin
      errors++; $display("FAIL rstmid_pending_dropped: got busy=%0d done=%0d expected 0 0", busy_seen, done_seen);
    end
    rx_q.delete();
    n = $urandom();
    bus.gold_nonce = n;
    bus.go_success = 1'b1;
    build_expected(K_SUCCESS, n, 8'h00);
    run_frame(-1, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
    got = rx_string(); exp = exp_string();
    checks++; if (to || got != exp) begin errors++; $display("FAIL rstmid_fresh_bytes: got %s expected %s", got, exp); end
    checks++; if (bc !== 6 * BYTE_CLKS || dc !== 1) begin
      errors++; $display("FAIL rstmid_fresh_timing: got busy=%0d done=%0d expected %0d 1", bc, dc, 6 * BYTE_CLKS);
    end
  endtask

  task automatic test_random();
    int rw, bc, dc, da, as, au, ac, tl, nbytes, exp_ack;
    bit to;
    string got, exp;
    kind_t k;
    logic [31:0] n;
    logic [7:0]  hf;
    for (int it = 0; it < 8; it++) begin
      k  = kind_t'($urandom_range(0, 2));
      n  = $urandom();
      hf = 8'($urandom());
      repeat ($urandom_range(0, 5)) @(posedge clk_25);
      #1;
      bus.gold_nonce     = n;
      bus.hash_frequency = hf;
      case (k)
        K_SUCCESS:  bus.go_success  = 1'b1;
        K_RECONFIG: bus.reconfig_ok = 1'b1;
        default:    bus.go_unsucces = 1'b1;
      endcase
      build_expected(k, n, hf);
      nbytes  = exp_q.size();
      exp_ack = (k == K_RECONFIG) ? 0 : 1;
      run_frame(-1, 1'b0, rw, bc, dc, da, as, au, ac, tl, to);
      got = rx_string(); exp = exp_string();
      checks++; if (to || got != exp) begin errors++; $display("FAIL random_bytes[%0d]: got %s expected %s", it, got, exp); end
      checks++; if (bc !== nbytes * BYTE_CLKS || dc !== 1 || ac !== exp_ack) begin
        errors++; $display("FAIL random_timing[%0d]: got busy=%0d done=%0d acks=%0d expected %0d 1 %0d",
                           it, bc, dc, ac, nbytes * BYTE_CLKS, exp_ack);
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go_success     = 1'b0;
    bus.go_unsucces    = 1'b0;
    bus.reconfig_ok    = 1'b0;
    bus.gold_nonce     = 32'h0;
    bus.hash_frequency = 8'h0;
    host_break         = 1'b1;
    test_reset();
    test_success(1'b0);
    test_success(1'b1);
    test_simultaneous();
    test_request_while_busy();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
